// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU MEM-stage register bus into the interrupt controller
interface irq_controller_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: edge-captured, fixed-priority interrupt controller with EOI-gated service
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_irq,
  irq_controller_if.slave      bus,
  input  logic                 PC_31,
  output logic                 irqout,
  output logic [2:0]           irq_id
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t             r_state;
  logic [NUM_SRC-1:0] r_src_d, r_pending, r_enable;
  logic               r_irqout, r_in_service;
  logic [2:0]         r_irq_id;
  logic               w_sel, w_wr_pend, w_wr_en, w_eoi, w_acc, w_id_live;
  logic [1:0]         w_off;
  logic [NUM_SRC-1:0] w_rise, w_pe, w_clr, w_id_mask, w_pend_nxt;
  logic [2:0]         w_first;
  logic               w_unused;
  assign w_sel      = bus.addr[31:4] == BASE_ADDR[31:4];
  assign w_off      = bus.addr[3:2];
  assign w_wr_pend  = bus.wr && w_sel && w_off == 2'd0;
  assign w_wr_en    = bus.wr && w_sel && w_off == 2'd1;
  assign w_eoi      = bus.wr && w_sel && w_off == 2'd3;
  assign w_rise     = src_irq & ~r_src_d;
  assign w_pe       = r_pending & r_enable;
  assign w_clr      = w_wr_pend ? bus.wdata[NUM_SRC-1:0] : '0;
  assign w_id_mask  = NUM_SRC'(1) << r_irq_id;
  assign w_id_live  = |(w_id_mask & w_pe);
  assign w_acc      = r_state == REQ && PC_31;
  // a rise beats W1C, but acceptance of the in-flight source beats a same-cycle rise
  assign w_pend_nxt = ((r_pending & ~w_clr) | w_rise) & ~(w_acc ? w_id_mask : '0);
  assign w_unused   = &{1'b0, bus.addr[1:0], bus.wdata};
  always_comb begin
    w_first = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (w_pe[i]) w_first = 3'(i);
  end
  always_comb
    bus.rdata = !(bus.rd && w_sel) ? 32'd0 :
                w_off == 2'd0      ? 32'(r_pending) :
                w_off == 2'd1      ? 32'(r_enable) :
                w_off == 2'd2      ? {r_in_service, 28'd0, r_irq_id} : 32'd0;
  always_ff @(posedge sysclk) begin
    r_src_d <= src_irq;
    if (reset) begin
      r_pending    <= '0;
      r_enable     <= '0;
      r_state      <= IDLE;
      r_irqout     <= 1'b0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      if (w_wr_en) r_enable <= bus.wdata[NUM_SRC-1:0];
      case (r_state)
        IDLE: if (|w_pe && !PC_31) begin
          r_state  <= REQ;
          r_irq_id <= w_first;
          r_irqout <= 1'b1;
        end
        REQ: if (PC_31) begin
          r_state      <= SERVICE;
          r_irqout     <= 1'b0;
          r_in_service <= 1'b1;
        end else if (!w_id_live) begin
          r_state  <= IDLE;
          r_irqout <= 1'b0;
        end
        default: if (w_eoi) begin
          r_state      <= IDLE;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end
  assign irqout = r_irqout;
  assign irq_id = r_irq_id;
endmodule
